// File: rtl/add_vec_player.sv
// Vector player/checker for the single-precision adder + rounding path.
// Streams {in1, in2, exp} words from a synchronous ROM, drives the datapath and tallies mismatches.
module add_vec_player #(
    parameter int ADDR_W = 10,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W:0]   num_vec,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [95:0]       rom_data,
    output logic [31:0]       dut_in1,
    output logic [31:0]       dut_in2,
    output logic              RNE,
    output logic              RTZ,
    output logic              RDN,
    output logic              RUP,
    output logic              RMM,
    input  logic [31:0]       dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W:0]   test_cnt,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [31:0]       first_err_act
);
    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_CHECK, S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg;
    logic [ADDR_W:0]     num_vec_reg;
    logic [4:0]          mode_oh_reg;   // {RMM, RUP, RDN, RTZ, RNE}
    logic [31:0]         in1_reg, in2_reg, exp_reg;
    logic [CNT_W-1:0]    settle_reg;
    logic [ADDR_W:0]     err_reg, test_reg;
    logic [ADDR_W-1:0]   ferr_idx_reg;
    logic [31:0]         ferr_act_reg;
    logic                ferr_flag_reg;

    logic                start_ok;
    logic [ADDR_W:0]     last_idx;
    logic                is_last;
    logic                mismatch;
    logic [4:0]          mode_oh;

    assign start_ok = start && (state_reg == S_IDLE || state_reg == S_DONE);
    assign last_idx = num_vec_reg - 1'b1;
    // Stopping at the all-ones index too keeps an oversized num_vec from wrapping the address.
    assign is_last  = ({1'b0, idx_reg} == last_idx) || (&idx_reg);
    assign mismatch = (dut_out != exp_reg);

    always_comb begin
        mode_oh = 5'b00001;
        case (mode)
            3'd1:    mode_oh = 5'b00010;
            3'd2:    mode_oh = 5'b00100;
            3'd3:    mode_oh = 5'b01000;
            3'd4:    mode_oh = 5'b10000;
            default: mode_oh = 5'b00001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) state_next = (num_vec == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH:  state_next = S_LOAD;
            S_LOAD:   state_next = S_SETTLE;
            S_SETTLE: if (settle_reg == CNT_W'(1)) state_next = S_CHECK;
            S_CHECK:  state_next = is_last ? S_DONE : S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            num_vec_reg   <= '0;
            mode_oh_reg   <= 5'b00001;
            in1_reg       <= '0;
            in2_reg       <= '0;
            exp_reg       <= '0;
            settle_reg    <= '0;
            err_reg       <= '0;
            test_reg      <= '0;
            ferr_idx_reg  <= '0;
            ferr_act_reg  <= '0;
            ferr_flag_reg <= 1'b0;
        end else begin
            if (start_ok) begin
                idx_reg       <= '0;
                num_vec_reg   <= num_vec;
                mode_oh_reg   <= mode_oh;
                err_reg       <= '0;
                test_reg      <= '0;
                ferr_idx_reg  <= '0;
                ferr_act_reg  <= '0;
                ferr_flag_reg <= 1'b0;
            end
            case (state_reg)
                S_LOAD: begin
                    in1_reg    <= rom_data[95:64];
                    in2_reg    <= rom_data[63:32];
                    exp_reg    <= rom_data[31:0];
                    settle_reg <= CNT_W'(SETTLE);
                end
                S_SETTLE: begin
                    if (settle_reg != CNT_W'(1)) settle_reg <= settle_reg - 1'b1;
                end
                S_CHECK: begin
                    test_reg <= test_reg + 1'b1;
                    if (mismatch) begin
                        err_reg <= err_reg + 1'b1;
                        if (!ferr_flag_reg) begin
                            ferr_idx_reg  <= idx_reg;
                            ferr_act_reg  <= dut_out;
                            ferr_flag_reg <= 1'b1;
                        end
                    end
                    if (!is_last) idx_reg <= idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rom_en        = (state_reg == S_FETCH);
    assign rom_addr      = idx_reg;
    assign dut_in1       = in1_reg;
    assign dut_in2       = in2_reg;
    assign RNE           = mode_oh_reg[0];
    assign RTZ           = mode_oh_reg[1];
    assign RDN           = mode_oh_reg[2];
    assign RUP           = mode_oh_reg[3];
    assign RMM           = mode_oh_reg[4];
    assign busy          = (state_reg == S_FETCH) || (state_reg == S_LOAD) ||
                           (state_reg == S_SETTLE) || (state_reg == S_CHECK);
    assign done          = (state_reg == S_DONE);
    assign pass          = done && (err_reg == '0);
    assign err_cnt       = err_reg;
    assign test_cnt      = test_reg;
    assign first_err_idx = ferr_idx_reg;
    assign first_err_act = ferr_act_reg;
endmodule

// File: tb/tb_add_vec_player.sv
// Directed bench for add_vec_player: a behavioural ROM plus a lookup adder for the vectors in use.
module tb_add_vec_player;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start4;
    logic [2:0]    mode;
    logic [AW:0]   num_vec, num_vec4;
    logic [95:0]   rom [16];

    logic          rom_en, rom_en4;
    logic [AW-1:0] rom_addr, rom_addr4;
    logic [95:0]   rom_data, rom_data4;
    logic [31:0]   in1, in2, in1_4, in2_4, dout, dout4;
    logic          rne, rtz, rdn, rup, rmm;
    logic          rne4, rtz4, rdn4, rup4, rmm4;
    logic          busy, done, pass, busy4, done4, pass4;
    logic [AW:0]   err, tst, err4, tst4;
    logic [AW-1:0] fidx, fidx4;
    logic [31:0]   fact, fact4;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3f800000 && b == 32'h3f800000) return 32'h40000000;
        if (a == 32'h40400000 && b == 32'hbf800000) return 32'h40000000;
        if (a == 32'h00000000 && b == 32'h80000000) return 32'h00000000;
        return 32'hffffffff;
    endfunction

    always_ff @(posedge clk) begin
        if (rom_en)  rom_data  <= rom[rom_addr];
        if (rom_en4) rom_data4 <= rom[rom_addr4];
    end
    assign dout  = fadd(in1, in2);
    assign dout4 = fadd(in1_4, in2_4);

    add_vec_player #(.ADDR_W(AW), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vec(num_vec),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .dut_in1(in1), .dut_in2(in2),
        .RNE(rne), .RTZ(rtz), .RDN(rdn), .RUP(rup), .RMM(rmm),
        .dut_out(dout), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err), .test_cnt(tst), .first_err_idx(fidx), .first_err_act(fact)
    );

    add_vec_player #(.ADDR_W(AW), .SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode), .num_vec(num_vec4),
        .rom_en(rom_en4), .rom_addr(rom_addr4), .rom_data(rom_data4),
        .dut_in1(in1_4), .dut_in2(in2_4),
        .RNE(rne4), .RTZ(rtz4), .RDN(rdn4), .RUP(rup4), .RMM(rmm4),
        .dut_out(dout4), .busy(busy4), .done(done4), .pass(pass4),
        .err_cnt(err4), .test_cnt(tst4), .first_err_idx(fidx4), .first_err_act(fact4)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("ok   %-14s observed=%h expected=%h", tag, obs, exp);
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [2:0] m, input logic [AW:0] n);
        mode = m; num_vec = n; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; mode = 3'd0; num_vec = '0; num_vec4 = '0;
        for (int i = 0; i < 16; i++) rom[i] = {32'h3f800000, 32'h3f800000, 32'h40000000};
        rom[1] = {32'h40400000, 32'hbf800000, 32'h40000000};
        rom[2] = {32'h00000000, 32'h80000000, 32'h00000000};
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_modes", 32'({rmm, rup, rdn, rtz, rne}), 32'h01);
        chk("rst_test_cnt", 32'(tst), 32'd0);

        // Three good vectors, RNE
        go(3'd0, 5'd3);
        chk("t1_fetch_busy", 32'(busy), 32'd1);
        chk("t1_fetch_rom_en", 32'(rom_en), 32'd1);
        chk("t1_fetch_addr", 32'(rom_addr), 32'd0);
        tick(11);
        chk("t1_done_early", 32'(done), 32'd0);
        tick(1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_test", 32'(tst), 32'd3);
        chk("t1_pass", 32'(pass), 32'd1);

        // Corrupted expectation on vector 1
        rom[1][31:0] = 32'h40000001;
        go(3'd0, 5'd3);
        tick(12);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_fidx", 32'(fidx), 32'd1);
        chk("t2_fact", fact, 32'h40000000);
        chk("t2_pass", 32'(pass), 32'd0);
        rom[1][31:0] = 32'h40000000;

        // Mode lines: no change until start accepted, then RUP throughout
        mode = 3'd3;
        tick(1);
        chk("t3_hold_modes", 32'({rmm, rup, rdn, rtz, rne}), 32'h01);
        go(3'd3, 5'd3);
        chk("t3_rup_start", 32'({rmm, rup, rdn, rtz, rne}), 32'h08);
        tick(6);
        chk("t3_rup_mid", 32'({rmm, rup, rdn, rtz, rne}), 32'h08);
        tick(6);
        chk("t3_rup_done", 32'({rmm, rup, rdn, rtz, rne}), 32'h08);
        chk("t3_done", 32'(done), 32'd1);
        go(3'd6, 5'd1);
        chk("t3_mode6", 32'({rmm, rup, rdn, rtz, rne}), 32'h01);
        tick(4);
        chk("t3_m6_test", 32'(tst), 32'd1);

        // Empty run
        go(3'd0, 5'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_pass", 32'(pass), 32'd1);
        chk("t4_test", 32'(tst), 32'd0);
        chk("t4_rom_en", 32'(rom_en), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Start ignored during SETTLE, then reset in CHECK of vector 1
        go(3'd1, 5'd3);
        tick(2);
        start = 1'b1; num_vec = 5'd0;
        tick(1);
        start = 1'b0;
        chk("t5_ign_busy", 32'(busy), 32'd1);
        tick(4);
        chk("t5_v1_test", 32'(tst), 32'd1);
        chk("t5_v1_addr", 32'(rom_addr), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_addr", 32'(rom_addr), 32'd0);
        chk("t5_rst_in1", in1, 32'd0);
        chk("t5_rst_in2", in2, 32'd0);
        chk("t5_rst_test", 32'(tst), 32'd0);
        chk("t5_rst_modes", 32'({rmm, rup, rdn, rtz, rne}), 32'h01);
        go(3'd0, 5'd3);
        tick(12);
        chk("t5_rerun_done", 32'(done), 32'd1);
        chk("t5_rerun_test", 32'(tst), 32'd3);
        chk("t5_rerun_pass", 32'(pass), 32'd1);

        // SETTLE=4, two vectors
        num_vec4 = 5'd2; start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        chk("t6_addr0", 32'(rom_addr4), 32'd0);
        chk("t6_en0", 32'(rom_en4), 32'd1);
        tick(7);
        chk("t6_addr1", 32'(rom_addr4), 32'd1);
        chk("t6_en1", 32'(rom_en4), 32'd1);
        tick(6);
        chk("t6_done_early", 32'(done4), 32'd0);
        tick(1);
        chk("t6_done", 32'(done4), 32'd1);
        chk("t6_test", 32'(tst4), 32'd2);
        chk("t6_pass", 32'(pass4), 32'd1);

        // Full address space: 16 vectors, no wrap
        go(3'd0, 5'd16);
        tick(63);
        chk("t7_done_early", 32'(done), 32'd0);
        tick(1);
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_test", 32'(tst), 32'd16);
        chk("t7_addr", 32'(rom_addr), 32'd15);
        chk("t7_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
